// File: rtl/master_alu_pkg.sv
// Shared encodings for the master CPU ALU: opcodes, ARM condition codes and
// NZCV flag bit positions.
package master_alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_ORR = 4'h1;
    localparam logic [3:0] OP_EOR = 4'h2;
    localparam logic [3:0] OP_BIC = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SBC = 4'h7;
    localparam logic [3:0] OP_RSB = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_MVN = 4'hA;
    localparam logic [3:0] OP_LSL = 4'hB;
    localparam logic [3:0] OP_LSR = 4'hC;
    localparam logic [3:0] OP_ASR = 4'hD;
    localparam logic [3:0] OP_ROR = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational ARM condition-code evaluation against the current NZCV flags.
module alu_cond_check
    import master_alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flag_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flag_i[FLAG_N];
    assign z = flag_i[FLAG_Z];
    assign c = flag_i[FLAG_C];
    assign v = flag_i[FLAG_V];

    // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/master_alu.sv
// Registered 32-bit ARM-style ALU: conditional execution, optional NZCV update,
// one-cycle latency from operand sampling to Result/New_Flag/Cond_pass.
module master_alu
    import master_alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  iv_i,
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  cond_i,
    input  logic        s_i,
    input  logic [3:0]  flag_i,
    output logic [31:0] result_o,
    output logic [3:0]  new_flag_o,
    output logic        cond_pass_o
);

    logic        cond_ok;
    logic [31:0] add_x, add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic        arith_v;
    logic [4:0]  lsl_idx, lsr_idx;
    logic [31:0] shift_res;
    logic        shift_c;
    logic [31:0] op_res;
    logic        op_c, op_v;
    logic [31:0] result_d, result_q;
    logic [3:0]  flag_d, flag_q;
    logic        pass_d, pass_q;

    alu_cond_check u_cond_check (
        .cond_i (cond_i),
        .flag_i (flag_i),
        .pass_o (cond_ok)
    );

    // Every add/subtract variant is folded into one 33-bit adder: x + y + cin,
    // with subtraction as x + ~y + 1 so the carry-out is already NOT-borrow.
    always_comb begin
        add_x   = reg1_i;
        add_y   = reg2_i;
        add_cin = 1'b0;
        case (opcode_i)
            OP_ADC: add_cin = flag_i[FLAG_C];
            OP_SUB, OP_CMP: begin
                add_y   = ~reg2_i;
                add_cin = 1'b1;
            end
            OP_SBC: begin
                add_y   = ~reg2_i;
                add_cin = flag_i[FLAG_C];
            end
            OP_RSB: begin
                add_x   = reg2_i;
                add_y   = ~reg1_i;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum     = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    assign arith_v = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);

    // Bit index of the last bit shifted out: 32-IV for left, IV-1 for right.
    assign lsl_idx = 5'd0 - iv_i;
    assign lsr_idx = iv_i - 5'd1;

    always_comb begin
        shift_res = reg1_i;
        shift_c   = flag_i[FLAG_C];
        if (iv_i != 5'd0) begin
            case (opcode_i)
                OP_LSL: begin
                    shift_res = reg1_i << iv_i;
                    shift_c   = reg1_i[lsl_idx];
                end
                OP_LSR: begin
                    shift_res = reg1_i >> iv_i;
                    shift_c   = reg1_i[lsr_idx];
                end
                OP_ASR: begin
                    shift_res = $signed(reg1_i) >>> iv_i;
                    shift_c   = reg1_i[lsr_idx];
                end
                OP_ROR: begin
                    shift_res = (reg1_i >> iv_i) | (reg1_i << (6'd32 - {1'b0, iv_i}));
                    shift_c   = reg1_i[lsr_idx];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        op_res = '0;
        op_c   = flag_i[FLAG_C];
        op_v   = flag_i[FLAG_V];
        case (opcode_i)
            OP_AND: op_res = reg1_i & reg2_i;
            OP_ORR: op_res = reg1_i | reg2_i;
            OP_EOR: op_res = reg1_i ^ reg2_i;
            OP_BIC: op_res = reg1_i & ~reg2_i;
            OP_MOV: op_res = reg2_i;
            OP_MVN: op_res = ~reg2_i;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB, OP_CMP: begin
                op_res = sum[31:0];
                op_c   = sum[32];
                op_v   = arith_v;
            end
            OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
                op_res = shift_res;
                op_c   = shift_c;
            end
        endcase
    end

    // A failed condition holds Result and passes the incoming flags straight through.
    always_comb begin
        result_d = result_q;
        flag_d   = flag_i;
        pass_d   = 1'b0;
        if (cond_ok) begin
            pass_d = 1'b1;
            if (opcode_i != OP_CMP) begin
                result_d = op_res;
            end
            if (s_i || (opcode_i == OP_CMP)) begin
                flag_d = {op_res[31], (op_res == 32'd0), op_c, op_v};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            flag_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
            pass_q   <= pass_d;
        end
    end

    assign result_o    = result_q;
    assign new_flag_o  = flag_q;
    assign cond_pass_o = pass_q;

endmodule

// File: tb/tb_master_alu.sv
// Scoreboard bench for master_alu: directed vectors push hand-computed
// expectations, a monitor pops and compares one cycle later.
module tb_master_alu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  iv_i = '0;
    logic [3:0]  opcode_i = '0;
    logic [3:0]  cond_i = 4'hE;
    logic        s_i = 1'b0;
    logic [3:0]  flag_i = '0;
    logic [31:0] result_o;
    logic [3:0]  new_flag_o;
    logic        cond_pass_o;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic        pass;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    master_alu dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .iv_i        (iv_i),
        .opcode_i    (opcode_i),
        .cond_i      (cond_i),
        .s_i         (s_i),
        .flag_i      (flag_i),
        .result_o    (result_o),
        .new_flag_o  (new_flag_o),
        .cond_pass_o (cond_pass_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one operation at the falling edge and record what should appear after the next rising edge.
    task automatic issue(input string name, input logic rst, input logic [3:0] op, input logic [3:0] cond,
                         input logic s, input logic [3:0] flg, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] iv, input logic [31:0] e_res, input logic [3:0] e_flg,
                         input logic e_pass);
        exp_t e;
        @(negedge clk_i);
        rst_i    = rst;
        opcode_i = op;
        cond_i   = cond;
        s_i      = s;
        flag_i   = flg;
        reg1_i   = a;
        reg2_i   = b;
        iv_i     = iv;
        e.res  = e_res;
        e.flg  = e_flg;
        e.pass = e_pass;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are live every cycle, compared 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".result"}, result_o, e.res);
                check({e.name, ".flags"}, {28'd0, new_flag_o}, {28'd0, e.flg});
                check({e.name, ".pass"}, {31'd0, cond_pass_o}, {31'd0, e.pass});
            end
        end
    end

    initial begin
        //     name          rst   op    cond  s     flag     A              B              iv     result         flags    pass
        issue("reset",       1'b1, 4'h4, 4'hE, 1'b1, 4'b1111, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0000, 4'b0000, 1'b0);
        issue("add_ovf",     1'b0, 4'h4, 4'hE, 1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 4'b1001, 1'b1);
        issue("sub_zero_s",  1'b0, 4'h6, 4'hE, 1'b1, 4'b0000, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 4'b0110, 1'b1);
        issue("sub_zero_ns", 1'b0, 4'h6, 4'hE, 1'b0, 4'b0000, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 4'b0000, 1'b1);
        issue("mov_12",      1'b0, 4'h9, 4'hE, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0012, 5'd0,  32'h0000_0012, 4'b0000, 1'b1);
        issue("eq_fail",     1'b0, 4'h4, 4'h0, 1'b1, 4'b0000, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0012, 4'b0000, 1'b0);
        issue("nv_fail",     1'b0, 4'h4, 4'hF, 1'b1, 4'b1111, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0012, 4'b1111, 1'b0);
        issue("asr_4",       1'b0, 4'hD, 4'hE, 1'b1, 4'b0000, 32'h8000_0010, 32'h0000_0000, 5'd4,  32'hF800_0001, 4'b1000, 1'b1);
        issue("asr_0",       1'b0, 4'hD, 4'hE, 1'b1, 4'b0010, 32'h8000_0010, 32'h0000_0000, 5'd0,  32'h8000_0010, 4'b1010, 1'b1);
        issue("mov_55",      1'b0, 4'h9, 4'hE, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0055, 5'd0,  32'h0000_0055, 4'b0000, 1'b1);
        issue("cmp_3_7",     1'b0, 4'hF, 4'hE, 1'b0, 4'b0000, 32'h0000_0003, 32'h0000_0007, 5'd0,  32'h0000_0055, 4'b1000, 1'b1);
        issue("adc_carry",   1'b0, 4'h5, 4'hE, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  32'h0000_0000, 4'b0110, 1'b1);
        issue("sbc_borrow",  1'b0, 4'h7, 4'hE, 1'b1, 4'b0000, 32'h0000_000A, 32'h0000_0003, 5'd0,  32'h0000_0006, 4'b0010, 1'b1);
        issue("rsb",         1'b0, 4'h8, 4'hE, 1'b1, 4'b0000, 32'h0000_0003, 32'h0000_000A, 5'd0,  32'h0000_0007, 4'b0010, 1'b1);
        issue("sub_ovf",     1'b0, 4'h6, 4'hE, 1'b1, 4'b0000, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 4'b0011, 1'b1);
        issue("lsl_1",       1'b0, 4'hB, 4'hE, 1'b1, 4'b0000, 32'h8000_0001, 32'h0000_0000, 5'd1,  32'h0000_0002, 4'b0010, 1'b1);
        issue("lsr_1",       1'b0, 4'hC, 4'hE, 1'b1, 4'b0000, 32'h0000_0003, 32'h0000_0000, 5'd1,  32'h0000_0001, 4'b0010, 1'b1);
        issue("ror_1",       1'b0, 4'hE, 4'hE, 1'b1, 4'b0000, 32'h0000_0001, 32'h0000_0000, 5'd1,  32'h8000_0000, 4'b1010, 1'b1);
        issue("lsl_31",      1'b0, 4'hB, 4'hE, 1'b1, 4'b0000, 32'h0000_0003, 32'h0000_0000, 5'd31, 32'h8000_0000, 4'b1010, 1'b1);
        issue("and",         1'b0, 4'h0, 4'hE, 1'b1, 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 4'b0011, 1'b1);
        issue("orr",         1'b0, 4'h1, 4'hE, 1'b0, 4'b0000, 32'h0000_00F0, 32'h0000_000F, 5'd0,  32'h0000_00FF, 4'b0000, 1'b1);
        issue("eor",         1'b0, 4'h2, 4'hE, 1'b1, 4'b0000, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0,  32'hFFFF_FFFF, 4'b1000, 1'b1);
        issue("bic",         1'b0, 4'h3, 4'hE, 1'b0, 4'b0101, 32'hFFFF_FFFF, 32'h0000_FFFF, 5'd0,  32'hFFFF_0000, 4'b0101, 1'b1);
        issue("mvn",         1'b0, 4'hA, 4'hE, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 4'b1000, 1'b1);
        issue("ge_pass",     1'b0, 4'h4, 4'hA, 1'b0, 4'b1001, 32'h0000_0001, 32'h0000_0002, 5'd0,  32'h0000_0003, 4'b1001, 1'b1);
        issue("lt_pass",     1'b0, 4'h9, 4'hB, 1'b0, 4'b1000, 32'h0000_0000, 32'h0000_0009, 5'd0,  32'h0000_0009, 4'b1000, 1'b1);
        issue("hi_pass",     1'b0, 4'h9, 4'h8, 1'b0, 4'b0010, 32'h0000_0000, 32'h0000_0007, 5'd0,  32'h0000_0007, 4'b0010, 1'b1);
        issue("ls_fail",     1'b0, 4'h9, 4'h9, 1'b1, 4'b0010, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'h0000_0007, 4'b0010, 1'b0);
        issue("gt_fail",     1'b0, 4'h9, 4'hC, 1'b1, 4'b0100, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'h0000_0007, 4'b0100, 1'b0);
        issue("ne_pass",     1'b0, 4'h9, 4'h1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0021, 5'd0,  32'h0000_0021, 4'b0000, 1'b1);
        issue("stream_add",  1'b0, 4'h4, 4'hE, 1'b0, 4'b0000, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0002, 4'b0000, 1'b1);
        issue("mid_reset",   1'b1, 4'h4, 4'hE, 1'b1, 4'b1111, 32'h0000_0003, 32'h0000_0003, 5'd0,  32'h0000_0000, 4'b0000, 1'b0);
        issue("post_reset",  1'b0, 4'h4, 4'hE, 1'b0, 4'b0000, 32'h0000_0002, 32'h0000_0002, 5'd0,  32'h0000_0004, 4'b0000, 1'b1);

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
